uart_sample_rx: RTL and testbench

//  - Receive end of the controller's com_UART link: 8N1 UART receiver for the RXD pin.
//  - Packs byte pairs (low byte first) into 16-bit signed audio samples.
//  - Presents each sample on a valid/ready port for the filtering path.
//  - Counterpart of the controller's TXD transmitter; same framing and bit period.

---
 rtl/uart_sample_rx_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 120 ++++++++++++
 rtl/uart_sample_rx.sv | 102 ++++++++++
 tb/tb_uart_sample_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sample_rx_pkg.sv
// Shared UART constants: receiver state codes, default bit period and sample width.
// The controller's TXD transmitter uses the same constants so both ends agree on framing.
package uart_sample_rx_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned UART_CLKS_PER_BIT = 434;

  // An audio sample is always two bytes, low byte first on the wire
  localparam int unsigned UART_SAMPLE_W = 16;

  typedef enum logic [2:0] {
    UART_IDLE  = 3'd0,
    UART_START = 3'd1,
    UART_DATA  = 3'd2,
    UART_STOP  = 3'd3,
    UART_BREAK = 3'd4
  } uart_state_e;

  // Which half of the sample the next accepted byte fills
  typedef enum logic {
    PHASE_LO = 1'b0,
    PHASE_HI = 1'b1
  } byte_phase_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop synchroniser on the raw pin plus a mid-bit sampling FSM.
// byte_valid and frame_err are single-cycle pulses; byte_out holds the last good byte.
module uart_rx_byte
  import uart_sample_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_key,
  input  logic       rxd,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  uart_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       byte_q;
  logic             byte_valid_q;
  logic             frame_err_q;

  // Two-flop synchroniser; resets to the idle-high line level so reset release is not a start edge
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rx_s = sync_q[1];

  // Receive FSM: detect start edge, confirm at mid start bit, then sample each bit centre
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      state_q      <= UART_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      unique case (state_q)
        UART_IDLE: begin
          if (!rx_s) begin
            state_q <= UART_START;
            cnt_q   <= '0;
          end
        end
        UART_START: begin
          if (cnt_q == CNT_MID) begin
            // Still low at mid start bit: real frame; otherwise a glitch, drop it silently
            if (!rx_s) begin
              state_q <= UART_DATA;
              cnt_q   <= '0;
              idx_q   <= '0;
            end else begin
              state_q <= UART_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        UART_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == 3'd7) begin
              state_q <= UART_STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        UART_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s) begin
              byte_q       <= shift_q;
              byte_valid_q <= 1'b1;
              state_q      <= UART_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= UART_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        UART_BREAK: begin
          // Hold here until the line recovers so a long break reports only one error
          if (rx_s) begin
            state_q <= UART_IDLE;
          end
        end
        default: begin
          state_q <= UART_IDLE;
        end
      endcase
    end
  end

  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/uart_sample_rx.sv
// UART sample receiver: pairs received bytes (low first) into 16-bit two's complement
// audio samples and offers them on a valid/ready port with a one-entry holding register.
module uart_sample_rx
  import uart_sample_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = UART_SAMPLE_W
) (
  input  logic              clk,
  input  logic              reset_key,
  input  logic              com_UART_RXD,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              frame_err,
  output logic              overrun
);

  logic [7:0]        byte_w;
  logic              byte_valid_w;
  logic              frame_err_w;

  byte_phase_e       phase_q, phase_d;
  logic [7:0]        lo_byte_q, lo_byte_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              sample_done;
  logic              reg_free;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx_byte (
    .clk        (clk),
    .reset_key  (reset_key),
    .rxd        (com_UART_RXD),
    .byte_out   (byte_w),
    .byte_valid (byte_valid_w),
    .frame_err  (frame_err_w)
  );

  assign sample_done = byte_valid_w && (phase_q == PHASE_HI);
  // The register can take a new sample if empty or being drained this very cycle
  assign reg_free    = !valid_q || sample_ready;

  // Byte pairing, holding-register load/drain and overrun detection
  always_comb begin
    phase_d   = phase_q;
    lo_byte_d = lo_byte_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    // A framing error realigns pairing so the next good byte is treated as a low byte
    if (frame_err_w) begin
      phase_d = PHASE_LO;
    end else if (byte_valid_w) begin
      if (phase_q == PHASE_LO) begin
        lo_byte_d = byte_w;
        phase_d   = PHASE_HI;
      end else begin
        phase_d = PHASE_LO;
      end
    end

    if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end

    if (sample_done) begin
      if (reg_free) begin
        sample_d = {byte_w, lo_byte_q};
        valid_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State registers for the assembler and output port
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      phase_q   <= PHASE_LO;
      lo_byte_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      lo_byte_q <= lo_byte_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = frame_err_w;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_uart_sample_rx.sv
// Self-checking bench for uart_sample_rx with a 16-clock bit period.
module tb_uart_sample_rx;

  localparam int CPB = 16;

  logic        clk;
  logic        reset_key;
  logic        com_UART_RXD;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_err;
  logic        overrun;

  uart_sample_rx #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (16)
  ) dut (
    .clk          (clk),
    .reset_key    (reset_key),
    .com_UART_RXD (com_UART_RXD),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] exp;
  } pair_vec_t;

  logic [15:0] exp_q[$];   // expected samples, pushed when stimulus is driven
  logic [15:0] obs_q[$];   // samples the DUT handed over, pushed by the monitor
  int fe_cnt = 0;
  int ov_cnt = 0;
  int n_pass = 0;
  int n_total = 0;

  // Monitor: record every handshake and count error pulses
  always @(negedge clk) begin
    if (reset_key) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (sample_valid && sample_ready) obs_q.push_back(sample_out);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    com_UART_RXD = v;
    repeat (CPB) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  // Wait (bounded) for n observed samples, then compare them against the scoreboard
  task automatic collect(input string name, input int n, input int budget);
    int waited;
    logic [15:0] e;
    logic [15:0] o;
    waited = 0;
    while (obs_q.size() < n && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    check({name, "_count"}, obs_q.size(), n);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check(name, {16'h0, o}, {16'h0, e});
      $display("sample %s: got %04h expected %04h", name, o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  pair_vec_t vecs[5];

  initial begin
    int fe0;
    int ov0;
    logic tx_done;

    vecs[0] = '{lo: 8'h34, hi: 8'h12, exp: 16'h1234};
    vecs[1] = '{lo: 8'h00, hi: 8'h00, exp: 16'h0000};
    vecs[2] = '{lo: 8'hFF, hi: 8'hFF, exp: 16'hFFFF};
    vecs[3] = '{lo: 8'h01, hi: 8'h80, exp: 16'h8001};
    vecs[4] = '{lo: 8'hAA, hi: 8'h55, exp: 16'h55AA};

    reset_key    = 1'b0;
    com_UART_RXD = 1'b1;
    sample_ready = 1'b0;
    tx_done      = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_sample_out", {16'h0, sample_out}, 32'h0);
    check("rst_valid", {31'h0, sample_valid}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    @(posedge clk);
    reset_key = 1'b1;
    repeat (3) @(posedge clk);

    // Table-driven byte pairs with the consumer always ready
    sample_ready = 1'b1;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    for (int v = 0; v < 5; v++) begin
      send_byte(vecs[v].lo, 1'b1);
      send_byte(vecs[v].hi, 1'b1);
      exp_q.push_back(vecs[v].exp);
      collect("pair", 1, 4 * CPB);
    end
    check("pairs_frame_err", fe_cnt - fe0, 0);
    check("pairs_overrun", ov_cnt - ov0, 0);

    // Short low glitch must be rejected without any output activity
    fe0 = fe_cnt;
    com_UART_RXD = 1'b0;
    repeat (4) @(posedge clk);
    com_UART_RXD = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    @(negedge clk);
    check("glitch_valid", {31'h0, sample_valid}, 32'h0);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    check("glitch_obs", obs_q.size(), 0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h11, 1'b1);
    exp_q.push_back(16'h1122);
    collect("after_glitch", 1, 4 * CPB);

    // Framing error: lone low byte, bad frame realigns pairing, next pair is clean
    fe0 = fe_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h55, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("ferr_pulse", fe_cnt - fe0, 1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hAB, 1'b1);
    exp_q.push_back(16'hABCD);
    collect("after_ferr", 1, 4 * CPB);

    // Held-low line reports exactly one framing error
    fe0 = fe_cnt;
    com_UART_RXD = 1'b0;
    repeat (14 * CPB) @(posedge clk);
    com_UART_RXD = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("break_one_ferr", fe_cnt - fe0, 1);
    check("break_no_sample", obs_q.size(), 0);

    // Overrun: consumer stalled while two samples arrive
    sample_ready = 1'b0;
    ov0 = ov_cnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    exp_q.push_back(16'h0001);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check("ovr_valid_held", {31'h0, sample_valid}, 32'h1);
    check("ovr_data_held", {16'h0, sample_out}, 32'h0001);
    check("ovr_pulse", ov_cnt - ov0, 1);
    sample_ready = 1'b1;
    collect("ovr_drain", 1, 4 * CPB);
    @(negedge clk);
    check("ovr_valid_clear", {31'h0, sample_valid}, 32'h0);

    // Reset mid-frame: lone low byte, then partial byte cut by reset during bit 3
    send_byte(8'h99, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    com_UART_RXD = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    reset_key = 1'b0;
    @(negedge clk);
    check("midrst_sample_out", {16'h0, sample_out}, 32'h0);
    check("midrst_valid", {31'h0, sample_valid}, 32'h0);
    check("midrst_fe_ov", {30'h0, frame_err, overrun}, 32'h0);
    repeat (5) @(posedge clk);
    com_UART_RXD = 1'b1;
    reset_key = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    check("midrst_no_stale", obs_q.size(), 0);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    exp_q.push_back(16'h5678);
    collect("after_rst", 1, 4 * CPB);

    // Back-to-back random stream with a randomly stalling consumer
    ov0 = ov_cnt;
    fork
      begin
        logic [15:0] s;
        for (int k = 0; k < 200; k++) begin
          s = 16'($urandom);
          send_byte(s[7:0], 1'b1);
          send_byte(s[15:8], 1'b1);
          exp_q.push_back(s);
        end
        tx_done = 1'b1;
      end
      begin
        int low_run;
        low_run = 0;
        while (!tx_done) begin
          @(posedge clk);
          #1;
          if (low_run >= 100 || $urandom_range(0, 3) == 0) begin
            sample_ready = 1'b1;
            low_run = 0;
          end else begin
            sample_ready = 1'b0;
            low_run++;
          end
        end
        sample_ready = 1'b1;
      end
    join
    collect("stream", 200, 10 * CPB);
    check("stream_overrun", ov_cnt - ov0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
